// File: rtl/pic_bounce_ctrl.sv
// rtl/pic_bounce_ctrl.sv - picture ROM read controller with per-frame bounce of the picture position
// Bouncing motion is built only when PIC_BOUNCE_EN is defined; otherwise the picture is centred and fixed.
module pic_bounce_ctrl #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int H_PIC   = 100,
  parameter int V_PIC   = 100,
  parameter int ADR_MAX = 9999,
  parameter int STEP    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        pause,
  output logic        rom_rden,
  output logic [13:0] rom_addr,
  output logic        pic_valid,
  output logic [9:0]  pic_x0,
  output logic [9:0]  pic_y0,
  output logic        edge_hit
);

  localparam logic [9:0] X_INIT = 10'((H_VALID - H_PIC) / 2);
  localparam logic [9:0] Y_INIT = 10'((V_VALID - V_PIC) / 2);

  logic        frame_tick;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] x_lo;
  logic [10:0] x_hi;
  logic [10:0] y_lo;
  logic [10:0] y_hi;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  // The read window is shifted one column left so ROM q lines up with the beam.
  assign x_lo = {1'b0, pic_x0} - 11'd1;
  assign x_hi = {1'b0, pic_x0} + 11'(H_PIC) - 11'd1;
  assign y_lo = {1'b0, pic_y0};
  assign y_hi = {1'b0, pic_y0} + 11'(V_PIC);

  assign rom_rden   = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
  assign frame_tick = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rom_addr  <= '0;
      pic_valid <= 1'b0;
    end else begin
      pic_valid <= rom_rden;
      if (frame_tick) begin
        rom_addr <= '0;
      end else if (rom_rden) begin
        rom_addr <= (rom_addr == 14'(ADR_MAX)) ? 14'd0 : rom_addr + 14'd1;
      end
    end
  end

`ifdef PIC_BOUNCE_EN
  localparam logic [10:0] X_MIN  = 11'd1;
  localparam logic [10:0] X_MAX  = 11'(H_VALID - H_PIC);
  localparam logic [10:0] Y_MIN  = 11'd0;
  localparam logic [10:0] Y_MAX  = 11'(V_VALID - V_PIC);
  localparam logic [10:0] STEP_W = 11'(STEP);

  typedef enum logic [1:0] {
    S_DRAW  = 2'd0,
    S_UPD_X = 2'd1,
    S_UPD_Y = 2'd2
  } state_t;

  state_t      state;
  logic        dir_x;
  logic        dir_y;
  logic [10:0] cur_x;
  logic [10:0] cur_y;
  logic [9:0]  nxt_x;
  logic [9:0]  nxt_y;
  logic        bnc_x;
  logic        bnc_y;

  assign cur_x = {1'b0, pic_x0};
  assign cur_y = {1'b0, pic_y0};

  // dir_* = 1 means moving right/down; landing exactly on a limit is a bounce.
  always_comb begin
    nxt_x = pic_x0;
    bnc_x = 1'b0;
    if (dir_x) begin
      if (cur_x + STEP_W >= X_MAX) begin
        nxt_x = X_MAX[9:0];
        bnc_x = 1'b1;
      end else begin
        nxt_x = 10'(cur_x + STEP_W);
      end
    end else begin
      if (cur_x <= X_MIN + STEP_W) begin
        nxt_x = X_MIN[9:0];
        bnc_x = 1'b1;
      end else begin
        nxt_x = 10'(cur_x - STEP_W);
      end
    end
  end

  always_comb begin
    nxt_y = pic_y0;
    bnc_y = 1'b0;
    if (dir_y) begin
      if (cur_y + STEP_W >= Y_MAX) begin
        nxt_y = Y_MAX[9:0];
        bnc_y = 1'b1;
      end else begin
        nxt_y = 10'(cur_y + STEP_W);
      end
    end else begin
      if (cur_y <= Y_MIN + STEP_W) begin
        nxt_y = Y_MIN[9:0];
        bnc_y = 1'b1;
      end else begin
        nxt_y = 10'(cur_y - STEP_W);
      end
    end
  end

  // y is untouched in S_UPD_X, so bnc_y there already predicts the S_UPD_Y outcome.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_DRAW;
      pic_x0   <= X_INIT;
      pic_y0   <= Y_INIT;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      edge_hit <= 1'b0;
    end else begin
      case (state)
        S_DRAW: begin
          edge_hit <= 1'b0;
          if (frame_tick && !pause) begin
            state <= S_UPD_X;
          end
        end
        S_UPD_X: begin
          pic_x0   <= nxt_x;
          edge_hit <= bnc_x | bnc_y;
          if (bnc_x) begin
            dir_x <= ~dir_x;
          end
          state <= S_UPD_Y;
        end
        S_UPD_Y: begin
          pic_y0   <= nxt_y;
          edge_hit <= 1'b0;
          if (bnc_y) begin
            dir_y <= ~dir_y;
          end
          state <= S_DRAW;
        end
        default: begin
          edge_hit <= 1'b0;
          state    <= S_DRAW;
        end
      endcase
    end
  end
`else
  localparam int unused_step = STEP;
  logic unused_pause;

  assign unused_pause = pause;
  assign pic_x0       = X_INIT;
  assign pic_y0       = Y_INIT;
  assign edge_hit     = 1'b0;
`endif

endmodule

// File: tb/tb_pic_bounce_ctrl.sv
// tb/tb_pic_bounce_ctrl.sv - directed bench for pic_bounce_ctrl
// Bounce scenarios run only when PIC_BOUNCE_EN is defined; the fixed-position build is checked otherwise.
module tb_pic_bounce_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [9:0]  pix_x   = 10'h3FF;
  logic [9:0]  pix_y   = 10'h3FF;
  logic        pause   = 1'b0;
  logic        rom_rden;
  logic [13:0] rom_addr;
  logic        pic_valid;
  logic [9:0]  pic_x0;
  logic [9:0]  pic_y0;
  logic        edge_hit;

  int n_checks = 0;
  int n_fail   = 0;

  int   fx0 = 270;
  int   fy0 = 190;
  logic prev_exp = 1'b0;
  int   exp_addr = 0;
  int   n_rden, n_valid, bad_rden, bad_valid, bad_addr;
  int   edge_cnt = 0;
  int   first_r, last_r, first_v, last_v, addr_l2;
  logic seen_l2;

  pic_bounce_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pause     (pause),
    .rom_rden  (rom_rden),
    .rom_addr  (rom_addr),
    .pic_valid (pic_valid),
    .pic_x0    (pic_x0),
    .pic_y0    (pic_y0),
    .edge_hit  (edge_hit)
  );

  always #5 sys_clk = ~sys_clk;

  // One pixel clock: drive the beam, observe on the falling edge, step past the rising edge.
  task automatic cycle(input logic [9:0] x, input logic [9:0] y);
    logic e;
    int   ix, iy;
    pix_x = x;
    pix_y = y;
    @(negedge sys_clk);
    ix = int'(x);
    iy = int'(y);
    e  = (ix >= fx0 - 1) && (ix < fx0 + 99) && (iy >= fy0) && (iy < fy0 + 100);
    if (rom_rden !== e) bad_rden++;
    if (pic_valid !== prev_exp) bad_valid++;
    if (rom_rden === 1'b1) n_rden++;
    if (pic_valid === 1'b1) n_valid++;
    if (edge_hit === 1'b1) edge_cnt++;
    if (iy == fy0) begin
      if (rom_rden === 1'b1) begin
        if (first_r < 0) first_r = ix;
        last_r = ix;
      end
      if (pic_valid === 1'b1) begin
        if (first_v < 0) first_v = ix;
        last_v = ix;
      end
    end
    if (iy == fy0 + 1 && rom_rden === 1'b1 && !seen_l2) begin
      addr_l2 = int'(rom_addr);
      seen_l2 = 1'b1;
    end
    if (e) begin
      if (rom_addr !== 14'(exp_addr)) bad_addr++;
      exp_addr = (exp_addr == 9999) ? 0 : exp_addr + 1;
    end
    if (ix == 639 && iy == 479) exp_addr = 0;
    prev_exp = e;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_stats(input int x0, input int y0);
    fx0 = x0; fy0 = y0; exp_addr = 0; prev_exp = 1'b0;
    n_rden = 0; n_valid = 0; bad_rden = 0; bad_valid = 0; bad_addr = 0;
    first_r = -1; last_r = -1; first_v = -1; last_v = -1; addr_l2 = -1; seen_l2 = 1'b0;
  endtask

  // Scans the picture rows plus one row above/below, with a small margin left/right.
  task automatic run_frame(input int x0, input int y0);
    int xs, xe;
    clear_stats(x0, y0);
    xs = (x0 >= 3) ? x0 - 3 : 0;
    xe = (x0 + 102 <= 638) ? x0 + 102 : 638;
    for (int y = y0 - 1; y <= y0 + 100; y++) begin
      if (y < 0 || y > 479) continue;
      for (int x = xs; x <= xe; x++) cycle(10'(x), 10'(y));
      cycle(10'h3FF, 10'h3FF);
      cycle(10'h3FF, 10'h3FF);
    end
  endtask

  task automatic do_tick(output int pulses);
    int e0;
    e0 = edge_cnt;
    cycle(10'd639, 10'd479);
    repeat (5) cycle(10'h3FF, 10'h3FF);
    pulses = edge_cnt - e0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cycle(10'h3FF, 10'h3FF);
    cycle(10'h3FF, 10'h3FF);
    sys_rst = 1'b0;
    n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
    n_checks++; if (pic_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pic_valid); end
    n_checks++; if (edge_hit !== 1'b0) begin n_fail++; $display("FAIL reset_edge: got %b expected 0", edge_hit); end
    n_checks++; if (pic_x0 !== 10'd270) begin n_fail++; $display("FAIL reset_x0: got %0d expected 270", pic_x0); end
    n_checks++; if (pic_y0 !== 10'd190) begin n_fail++; $display("FAIL reset_y0: got %0d expected 190", pic_y0); end
  endtask

  task automatic test_first_frame();
    run_frame(270, 190);
    n_checks++; if (n_rden != 10000) begin n_fail++; $display("FAIL f1_rden_count: got %0d expected 10000", n_rden); end
    n_checks++; if (n_valid != 10000) begin n_fail++; $display("FAIL f1_valid_count: got %0d expected 10000", n_valid); end
    n_checks++; if (bad_rden + bad_valid + bad_addr != 0) begin n_fail++; $display("FAIL f1_pixels: got rden/valid/addr errors %0d/%0d/%0d expected 0/0/0", bad_rden, bad_valid, bad_addr); end
    n_checks++; if (first_r != 269 || last_r != 368) begin n_fail++; $display("FAIL f1_rden_span: got %0d..%0d expected 269..368", first_r, last_r); end
    n_checks++; if (first_v != 270 || last_v != 369) begin n_fail++; $display("FAIL f1_valid_span: got %0d..%0d expected 270..369", first_v, last_v); end
    n_checks++; if (addr_l2 != 100) begin n_fail++; $display("FAIL f1_line2_addr: got %0d expected 100", addr_l2); end
    n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL f1_wrap_addr: got %0d expected 0", rom_addr); end
  endtask

  task automatic test_frame_update();
    int p, ex, ey;
`ifdef PIC_BOUNCE_EN
    ex = 272; ey = 192;
`else
    ex = 270; ey = 190;
`endif
    do_tick(p);
    n_checks++; if (int'(pic_x0) != ex || int'(pic_y0) != ey) begin n_fail++; $display("FAIL upd1_pos: got %0d/%0d expected %0d/%0d", pic_x0, pic_y0, ex, ey); end
    n_checks++; if (p != 0) begin n_fail++; $display("FAIL upd1_edge: got %0d pulses expected 0", p); end
    n_checks++; if (rom_addr !== 14'd0) begin n_fail++; $display("FAIL upd1_addr: got %0d expected 0", rom_addr); end
    run_frame(ex, ey);
    n_checks++; if (n_rden != 10000 || n_valid != 10000) begin n_fail++; $display("FAIL f2_counts: got %0d/%0d expected 10000/10000", n_rden, n_valid); end
    n_checks++; if (bad_rden + bad_valid + bad_addr != 0) begin n_fail++; $display("FAIL f2_pixels: got rden/valid/addr errors %0d/%0d/%0d expected 0/0/0", bad_rden, bad_valid, bad_addr); end
  endtask

`ifdef PIC_BOUNCE_EN
  task automatic test_bottom_right_bounce();
    int p, tot;
    tot = 0;
    for (int t = 2; t <= 94; t++) begin do_tick(p); tot += p; end
    n_checks++; if (tot != 0) begin n_fail++; $display("FAIL pre_bottom_edge: got %0d pulses expected 0", tot); end
    do_tick(p);
    n_checks++; if (p != 1) begin n_fail++; $display("FAIL bottom_edge: got %0d pulses expected 1", p); end
    n_checks++; if (pic_x0 !== 10'd460 || pic_y0 !== 10'd380) begin n_fail++; $display("FAIL bottom_pos: got %0d/%0d expected 460/380", pic_x0, pic_y0); end
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd462 || pic_y0 !== 10'd378 || p != 0) begin n_fail++; $display("FAIL after_bottom: got %0d/%0d pulses %0d expected 462/378 pulses 0", pic_x0, pic_y0, p); end
    tot = 0;
    for (int t = 97; t <= 134; t++) begin do_tick(p); tot += p; end
    n_checks++; if (tot != 0) begin n_fail++; $display("FAIL pre_right_edge: got %0d pulses expected 0", tot); end
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd540 || pic_y0 !== 10'd300 || p != 1) begin n_fail++; $display("FAIL right_bounce: got %0d/%0d pulses %0d expected 540/300 pulses 1", pic_x0, pic_y0, p); end
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd538 || pic_y0 !== 10'd298) begin n_fail++; $display("FAIL after_right: got %0d/%0d expected 538/298", pic_x0, pic_y0); end
  endtask

  task automatic test_pause();
    int p, tot;
    tot = 0;
    pause = 1'b1;
    repeat (3) begin do_tick(p); tot += p; end
    n_checks++; if (pic_x0 !== 10'd538 || pic_y0 !== 10'd298) begin n_fail++; $display("FAIL pause_pos: got %0d/%0d expected 538/298", pic_x0, pic_y0); end
    n_checks++; if (tot != 0) begin n_fail++; $display("FAIL pause_edge: got %0d pulses expected 0", tot); end
    pause = 1'b0;
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd536 || pic_y0 !== 10'd296) begin n_fail++; $display("FAIL pause_release: got %0d/%0d expected 536/296", pic_x0, pic_y0); end
  endtask

  task automatic test_left_bounce();
    int p, tot;
    tot = 0;
    for (int t = 138; t <= 404; t++) begin do_tick(p); tot += p; end
    n_checks++; if (tot != 1) begin n_fail++; $display("FAIL top_edge: got %0d pulses expected 1", tot); end
    n_checks++; if (pic_x0 !== 10'd2 || pic_y0 !== 10'd238) begin n_fail++; $display("FAIL pre_left_pos: got %0d/%0d expected 2/238", pic_x0, pic_y0); end
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd1 || pic_y0 !== 10'd240 || p != 1) begin n_fail++; $display("FAIL left_bounce: got %0d/%0d pulses %0d expected 1/240 pulses 1", pic_x0, pic_y0, p); end
    run_frame(1, 240);
    n_checks++; if (first_r != 0 || last_r != 99) begin n_fail++; $display("FAIL left_rden_span: got %0d..%0d expected 0..99", first_r, last_r); end
    n_checks++; if (n_rden != 10000 || bad_rden + bad_valid + bad_addr != 0) begin n_fail++; $display("FAIL left_frame: got reads %0d errors %0d expected 10000/0", n_rden, bad_rden + bad_valid + bad_addr); end
    do_tick(p);
    n_checks++; if (pic_x0 !== 10'd3 || pic_y0 !== 10'd242) begin n_fail++; $display("FAIL after_left: got %0d/%0d expected 3/242", pic_x0, pic_y0); end
  endtask
`else
  task automatic test_static();
    int p, tot;
    tot = 0;
    for (int t = 0; t < 5; t++) begin
      pause = t[0];
      do_tick(p);
      tot += p;
    end
    pause = 1'b0;
    n_checks++; if (pic_x0 !== 10'd270 || pic_y0 !== 10'd190) begin n_fail++; $display("FAIL static_pos: got %0d/%0d expected 270/190", pic_x0, pic_y0); end
    n_checks++; if (tot != 0) begin n_fail++; $display("FAIL static_edge: got %0d pulses expected 0", tot); end
  endtask
`endif

  task automatic test_midframe_reset();
    int x0, y0;
`ifdef PIC_BOUNCE_EN
    x0 = 3; y0 = 242;
`else
    x0 = 270; y0 = 190;
`endif
    clear_stats(x0, y0);
    for (int x = x0 - 1; x < x0 + 49; x++) cycle(10'(x), 10'd250);
    n_checks++; if (rom_addr !== 14'd50) begin n_fail++; $display("FAIL mid_addr: got %0d expected 50", rom_addr); end
    sys_rst = 1'b1;
    cycle(10'(x0 + 49), 10'd250);
    sys_rst = 1'b0;
    n_checks++; if (rom_addr !== 14'd0 || pic_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_regs: got addr %0d valid %b expected 0/0", rom_addr, pic_valid); end
    n_checks++; if (pic_x0 !== 10'd270 || pic_y0 !== 10'd190 || edge_hit !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pos: got %0d/%0d edge %b expected 270/190/0", pic_x0, pic_y0, edge_hit); end
    cycle(10'h3FF, 10'h3FF);
    run_frame(270, 190);
    n_checks++; if (n_rden != 10000 || n_valid != 10000) begin n_fail++; $display("FAIL restart_counts: got %0d/%0d expected 10000/10000", n_rden, n_valid); end
    n_checks++; if (bad_rden + bad_valid + bad_addr != 0) begin n_fail++; $display("FAIL restart_pixels: got rden/valid/addr errors %0d/%0d/%0d expected 0/0/0", bad_rden, bad_valid, bad_addr); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frame_update();
`ifdef PIC_BOUNCE_EN
    test_bottom_right_bounce();
    test_pause();
    test_left_bounce();
`else
    test_static();
`endif
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
